// File: rtl/ultrasonic_echo_if.sv
// Trig/echo bus between a ranging initiator (master) and the stand-in sensor (slave).
interface ultrasonic_echo_if;
    logic       i_trig;
    logic [7:0] i_dist_cm;
    logic       o_echo;
    logic       o_busy;
    logic       o_short_trig;

    modport master (
        output i_trig, i_dist_cm,
        input  o_echo, o_busy, o_short_trig
    );

    modport slave (
        input  i_trig, i_dist_cm,
        output o_echo, o_busy, o_short_trig
    );
endinterface

// File: rtl/ultrasonic_echo_model.sv
// HC-SR04 responder model: validates the trig width, waits out the burst, then
// returns an echo whose width encodes the programmed distance.
module ultrasonic_echo_model #(
    parameter int TRIG_MIN_CYC = 500,
    parameter int BURST_CYC    = 10000,
    parameter int CYC_PER_CM   = 2900,
    parameter int MAX_CM       = 200,
    parameter int TIMEOUT_CYC  = 1900000,
    parameter int HOLDOFF_CYC  = 50000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    ultrasonic_echo_if.slave  bus
);
    localparam int MAX_W = (TIMEOUT_CYC > MAX_CM * CYC_PER_CM) ? TIMEOUT_CYC : MAX_CM * CYC_PER_CM;
    localparam int CW    = $clog2(MAX_W + 1);

    localparam logic [CW-1:0] TRIG_MIN = CW'(TRIG_MIN_CYC);
    localparam logic [CW-1:0] BURST    = CW'(BURST_CYC);
    localparam logic [CW-1:0] CPC      = CW'(CYC_PER_CM);
    localparam logic [CW-1:0] TIMEOUT  = CW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] HOLDOFF  = CW'(HOLDOFF_CYC);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [7:0]    MAX_DIST = 8'(MAX_CM);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] TRIG_HI = 3'd1;
    localparam logic [2:0] BURST_S = 3'd2;
    localparam logic [2:0] ECHO    = 3'd3;
    localparam logic [2:0] HOLD_S  = 3'd4;

    logic [2:0]    state;
    logic          trig_s1, trig_s2, trig_d;
    logic          trig_rise, trig_fall;
    logic [CW-1:0] cnt;
    logic [CW-1:0] width;
    logic [CW-1:0] dist_width;
    logic          dist_oor;
    logic          echo, busy, short_trig;

    assign trig_rise  = trig_s2 & ~trig_d;
    assign trig_fall  = ~trig_s2 & trig_d;
    assign dist_oor   = (bus.i_dist_cm == '0) || (bus.i_dist_cm > MAX_DIST);
    assign dist_width = dist_oor ? TIMEOUT : CW'(bus.i_dist_cm) * CPC;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_d  <= 1'b0;
        end else begin
            trig_s1 <= bus.i_trig;
            trig_s2 <= trig_s1;
            trig_d  <= trig_s2;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            width      <= '0;
            echo       <= 1'b0;
            busy       <= 1'b0;
            short_trig <= 1'b0;
        end else begin
            short_trig <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig_rise) begin
                        state <= TRIG_HI;
                        cnt   <= ONE;
                        busy  <= 1'b1;
                    end
                end
                TRIG_HI: begin
                    if (trig_fall) begin
                        if (cnt >= TRIG_MIN) begin
                            state <= BURST_S;
                            width <= dist_width;
                            cnt   <= ONE;
                        end else begin
                            state      <= IDLE;
                            short_trig <= 1'b1;
                            busy       <= 1'b0;
                            cnt        <= '0;
                        end
                    end else if (cnt != TRIG_MIN) begin
                        cnt <= cnt + ONE;
                    end
                end
                BURST_S: begin
                    if (cnt == BURST) begin
                        state <= ECHO;
                        echo  <= 1'b1;
                        cnt   <= ONE;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                ECHO: begin
                    if (cnt == width) begin
                        state <= HOLD_S;
                        echo  <= 1'b0;
                        cnt   <= ONE;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                HOLD_S: begin
                    // Count saturates so a trig held across the end keeps us here until it drops.
                    if (cnt != HOLDOFF) begin
                        cnt <= cnt + ONE;
                    end else if (!trig_s2) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    echo  <= 1'b0;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.o_echo       = echo;
    assign bus.o_busy       = busy;
    assign bus.o_short_trig = short_trig;
endmodule

// File: tb/tb_ultrasonic_echo_model.sv
// Directed and randomized checks of the echo responder against a timing model
// built from trig width, synchroniser latency and the distance-to-width rule.
module tb_ultrasonic_echo_model;
    localparam int TMIN  = 5;
    localparam int BURST = 8;
    localparam int CPC   = 3;
    localparam int MAXCM = 20;
    localparam int TOUT  = 100;
    localparam int HOLD  = 10;
    // Raw trig edge -> registered reaction: 2 sync flops + 1 state edge.
    localparam int LAT   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    ultrasonic_echo_if bus();

    ultrasonic_echo_model #(
        .TRIG_MIN_CYC(TMIN),
        .BURST_CYC(BURST),
        .CYC_PER_CM(CPC),
        .MAX_CM(MAXCM),
        .TIMEOUT_CYC(TOUT),
        .HOLDOFF_CYC(HOLD)
    ) dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic int model_width(input int d);
        if (d == 0 || d > MAXCM) return TOUT;
        return d * CPC;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_accept(input int hi, input int d0, input int d1, input string tag);
        int busy_at, k, w, h;
        bit short_seen;
        busy_at    = 0;
        short_seen = 1'b0;
        bus.i_dist_cm = 8'(d0);
        bus.i_trig    = 1'b1;
        for (int i = 1; i <= hi; i++) begin
            @(negedge clk);
            if (bus.o_busy && busy_at == 0) busy_at = i;
        end
        bus.i_trig = 1'b0;
        check({tag, "/busy_rise"}, busy_at, LAT);
        k = 0;
        while (!bus.o_echo && k < BURST + 20) begin
            @(negedge clk);
            k++;
            if (k == 5) bus.i_dist_cm = 8'(d1);
            short_seen |= bus.o_short_trig;
        end
        check({tag, "/echo_delay"}, k, BURST + LAT);
        w = 0;
        while (bus.o_echo && w < TOUT + 20) begin
            w++;
            @(negedge clk);
        end
        check({tag, "/echo_width"}, w, model_width(d0));
        h = 0;
        while (bus.o_busy && h < HOLD + 20) begin
            h++;
            @(negedge clk);
        end
        check({tag, "/holdoff"}, h, HOLD);
        check({tag, "/no_short"}, int'(short_seen), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_short(input int hi, input string tag);
        int pulses, first;
        bit echo_seen;
        pulses    = 0;
        first     = 0;
        echo_seen = 1'b0;
        bus.i_trig = 1'b1;
        repeat (hi) @(negedge clk);
        bus.i_trig = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (bus.o_short_trig) begin
                pulses++;
                if (first == 0) first = k;
            end
            echo_seen |= bus.o_echo;
        end
        check({tag, "/short_pulses"}, pulses, 1);
        check({tag, "/short_at"}, first, LAT);
        check({tag, "/no_echo"}, int'(echo_seen), 0);
        check({tag, "/idle"}, int'(bus.o_busy), 0);
    endtask

    initial begin
        int k, w;
        bit seen;
        int hi, d0, d1;
        bus.i_trig    = 1'b0;
        bus.i_dist_cm = 8'd0;

        repeat (2) @(negedge clk);
        check("reset/echo", int'(bus.o_echo), 0);
        check("reset/busy", int'(bus.o_busy), 0);
        check("reset/short", int'(bus.o_short_trig), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run_accept(6, 7, 7, "t1");
        run_short(3, "t2");
        run_short(1, "t2b");
        run_accept(5, 5, 5, "min_width");
        run_short(4, "below_min");
        run_accept(6, 0, 0, "t3_zero");
        run_accept(6, 25, 25, "t3_over");
        run_accept(6, 21, 21, "just_over");
        run_accept(6, 1, 1, "one_cm");
        run_accept(7, 20, 1, "t4");

        // Second trig during echo, held through holdoff.
        bus.i_dist_cm = 8'd4;
        bus.i_trig    = 1'b1;
        repeat (6) @(negedge clk);
        bus.i_trig = 1'b0;
        k = 0;
        while (!bus.o_echo && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("t5/echo_up", int'(bus.o_echo), 1);
        repeat (3) @(negedge clk);
        bus.i_trig = 1'b1;
        w = 0;
        while (bus.o_echo && w < 50) begin
            w++;
            @(negedge clk);
        end
        check("t5/echo_rest", w, model_width(4) - 3);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            seen |= bus.o_echo;
        end
        check("t5/no_second_echo", int'(seen), 0);
        check("t5/held_busy", int'(bus.o_busy), 1);
        bus.i_trig = 1'b0;
        k = 0;
        while (bus.o_busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t5/release", k, LAT);
        repeat (3) @(negedge clk);
        run_accept(6, 5, 5, "t5_fresh");

        // Reset in the middle of an echo.
        bus.i_dist_cm = 8'd10;
        bus.i_trig    = 1'b1;
        repeat (6) @(negedge clk);
        bus.i_trig = 1'b0;
        k = 0;
        while (!bus.o_echo && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("t6/echo_up", int'(bus.o_echo), 1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6/echo_abort", int'(bus.o_echo), 0);
        check("t6/busy_abort", int'(bus.o_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_accept(6, 2, 2, "t6_after");

        for (int n = 0; n < 10; n++) begin
            hi = int'($urandom_range(8, 1));
            d0 = int'($urandom_range(30, 0));
            d1 = int'($urandom_range(30, 0));
            if (hi >= TMIN) run_accept(hi, d0, d1, $sformatf("rnd%0d", n));
            else run_short(hi, $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
